// File: rtl/four_12_12_st0_st_bias_update.sv
// ---------------------------------------------------------------------------
// four_12_12_st0_st_bias_update
//
// Holds DEPTH float_24_8 bias values and applies one gradient step per
// accepted error term: bias[idx] <= bias[idx] - err * 2^-LR_SHIFT.
// Each term occupies the block for three cycles (IDLE accept, CALC, WB).
// A back-to-back term to the same entry therefore always reads the value
// that the previous term wrote.
//
// float_24_8: {sgn[31], exp[30:23], man[22:0]}, hidden leading one,
// no denormals.
//
// Ports
//   clk         single clock, all state on its rising edge
//   reset       asynchronous active-high reset
//   load_valid  direct bias write (honoured only in IDLE, wins over err)
//   load_index  entry to load
//   load_data   value to load
//   err_valid   error term offered
//   err_ready   error term accepted this cycle (IDLE and no load)
//   err_index   target bias entry
//   err_data    back-propagated error term
//   err_last    final term of a batch
//   rd_index    forward-path read address
//   rd_data     registered read, read-before-write, 0 when out of range
//   done        high in the WB cycle of a term flagged err_last
//   idx_err     sticky out-of-range index flag, cleared only by reset
// ---------------------------------------------------------------------------
module four_12_12_st0_st_bias_update #(
   parameter int DEPTH    = 12,
   parameter int LR_SHIFT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [3:0]  load_index,
   input  logic [31:0] load_data,
   input  logic        err_valid,
   output logic        err_ready,
   input  logic [3:0]  err_index,
   input  logic [31:0] err_data,
   input  logic        err_last,
   input  logic [3:0]  rd_index,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        idx_err
);

   typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

   localparam logic [7:0] LR_EXP       = 8'(LR_SHIFT);
   localparam logic [7:0] STEP_MIN_EXP = 8'(LR_SHIFT + 10);

   state_t      state_q, state_d;
   logic [31:0] bias_q [DEPTH];
   logic [3:0]  idx_q;
   logic [31:0] err_q;
   logic        last_q;
   logic [31:0] op_q;
   logic [31:0] res_q;
   logic [31:0] rd_data_q;
   logic        idx_err_q;

   logic        accept, load_en, load_ok, err_ok, rd_ok, wb_ok;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [31:0] wr_data;

   assign load_ok = int'(load_index) < DEPTH;
   assign err_ok  = int'(err_index) < DEPTH;
   assign rd_ok   = int'(rd_index) < DEPTH;
   assign wb_ok   = int'(idx_q) < DEPTH;

   assign load_en = (state_q == IDLE) && load_valid;
   assign accept  = (state_q == IDLE) && !load_valid && err_valid;

   // Loads and write-backs never collide: a load needs IDLE, a write-back WB.
   assign wr_en   = (load_en && load_ok) || ((state_q == WB) && wb_ok);
   assign wr_idx  = load_en ? load_index : idx_q;
   assign wr_data = load_en ? load_data : res_q;

   // ---------------- FSM ----------------
   always_comb begin
      state_d   = state_q;
      err_ready = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            err_ready = !load_valid;
            if (accept) state_d = CALC;
         end
         CALC: state_d = WB;
         WB: begin
            done    = last_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- step + float add ----------------
   logic        a_sgn, b_sgn, a_big, step_zero, lead_found, round_up;
   logic [7:0]  a_exp, b_exp, big_exp, res_exp;
   logic [22:0] a_man, b_man;
   logic [25:0] a_m26, b_m26;
   logic [8:0]  exp_diff;
   logic signed [48:0] a_ext, b_ext, big_ext, small_sh, sum, abs_sum;
   logic [5:0]  lead_pos;
   logic [46:0] norm;
   logic [23:0] man_rnd;
   logic [31:0] sum_result;

   always_comb begin
      a_sgn = op_q[31];
      a_exp = op_q[30:23];
      a_man = op_q[22:0];
      // Step is the negated error scaled by 2^-LR_SHIFT (exponent only).
      b_sgn = ~err_q[31];
      b_exp = err_q[30:23] - LR_EXP;
      b_man = err_q[22:0];
      step_zero = err_q[30:23] < STEP_MIN_EXP;

      // 26-bit signed mantissas with 23 zero LSBs appended.
      a_m26 = {3'b001, a_man};
      if (a_sgn) a_m26 = -a_m26;
      b_m26 = {3'b001, b_man};
      if (b_sgn) b_m26 = -b_m26;
      a_ext = {a_m26, 23'b0};
      b_ext = {b_m26, 23'b0};

      a_big    = a_exp >= b_exp;
      big_exp  = a_big ? a_exp : b_exp;
      exp_diff = a_big ? {1'b0, a_exp - b_exp} : {1'b0, b_exp - a_exp};
      big_ext  = a_big ? a_ext : b_ext;
      small_sh = (a_big ? b_ext : a_ext) >>> exp_diff;
      sum      = big_ext + small_sh;
      abs_sum  = sum[48] ? -sum : sum;

      // Highest set bit within 47..36; bit 47 corresponds to index 1.
      lead_found = 1'b0;
      lead_pos   = 6'd0;
      for (int i = 36; i < 48; i++) begin
         if (abs_sum[i]) begin
            lead_found = 1'b1;
            lead_pos   = 6'(i);
         end
      end

      // Move the leading one to bit 47 (dropped by the cast), then round.
      norm     = 47'(abs_sum << (6'd47 - lead_pos));
      round_up = norm[23] & ((|norm[22:0]) | norm[24]);
      man_rnd  = {1'b0, norm[46:24]} + {23'b0, round_up};
      // exp = big + 2 - index, index = 48 - lead_pos; a rounding carry
      // bumps the exponent and leaves the mantissa field zero.
      res_exp  = big_exp + {2'b0, lead_pos} - 8'd46 + {7'b0, man_rnd[23]};

      if (step_zero)
         sum_result = op_q;
      else if (big_exp < 8'd10)
         sum_result = 32'h0;
      else if (!lead_found)
         sum_result = {sum[48], big_exp - 8'd11, 23'b0};
      else
         sum_result = {sum[48], res_exp, man_rnd[22:0]};
   end

   // ---------------- state and operand registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         err_q     <= '0;
         last_q    <= 1'b0;
         op_q      <= '0;
         res_q     <= '0;
         rd_data_q <= '0;
         idx_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_ok ? bias_q[rd_index] : 32'h0;
         if (accept) begin
            idx_q  <= err_index;
            err_q  <= err_data;
            last_q <= err_last;
            op_q   <= err_ok ? bias_q[err_index] : 32'h0;
         end
         if (state_q == CALC) res_q <= sum_result;
         if ((load_en && !load_ok) || (accept && !err_ok)) idx_err_q <= 1'b1;
      end
   end

   // ---------------- bias storage ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) bias_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_en && wr_idx == 4'(i)) bias_q[i] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;
   assign idx_err = idx_err_q;

endmodule

// File: tb/tb_four_12_12_st0_st_bias_update.sv
// ---------------------------------------------------------------------------
// Testbench for four_12_12_st0_st_bias_update.
// A reference model (real-number arithmetic plus an occupancy counter)
// tracks the expected bias contents and outputs; one process compares the
// DUT against it every cycle, and directed tasks add literal expectations.
// ---------------------------------------------------------------------------
module tb_four_12_12_st0_st_bias_update;

   localparam int DEPTH    = 12;
   localparam int LR_SHIFT = 4;

   logic        clk, reset;
   logic        load_valid, err_valid, err_last, err_ready, done, idx_err;
   logic [3:0]  load_index, err_index, rd_index;
   logic [31:0] load_data, err_data, rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   four_12_12_st0_st_bias_update #(.DEPTH(DEPTH), .LR_SHIFT(LR_SHIFT)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_index (load_index),
      .load_data  (load_data),
      .err_valid  (err_valid),
      .err_ready  (err_ready),
      .err_index  (err_index),
      .err_data   (err_data),
      .err_last   (err_last),
      .rd_index   (rd_index),
      .rd_data    (rd_data),
      .done       (done),
      .idx_err    (idx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- real-number float_24_8 model ----------------
   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real f2r(input logic [31:0] f);
      real m = 1.0 + real'(f[22:0]) / 8388608.0;
      m = m * pow2(int'(f[30:23]) - 127);
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real x);
      real a;
      int  e, man;
      logic s;
      if (x == 0.0) return 32'h0;
      s = x < 0.0;
      a = s ? -x : x;
      e = 127;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      man = $rtoi((a - 1.0) * 8388608.0 + 0.5);
      return {s, e[7:0], man[22:0]};
   endfunction

   function automatic logic [31:0] model_update(input logic [31:0] b, input logic [31:0] e);
      if (int'(e[30:23]) < LR_SHIFT + 10) return b;
      return r2f(f2r(b) - f2r(e) / pow2(LR_SHIFT));
   endfunction

   // ---------------- model state ----------------
   logic [31:0] m_bias [DEPTH];
   int          m_busy;     // cycles of occupancy remaining after accept
   logic [3:0]  m_idx;
   logic        m_last;
   logic [31:0] m_res;
   logic [31:0] exp_rd;
   logic        exp_idx_err;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) m_bias[i] <= 32'h0;
         m_busy <= 0; m_idx <= '0; m_last <= 1'b0; m_res <= '0;
         exp_rd <= '0; exp_idx_err <= 1'b0;
      end else begin
         exp_rd <= (int'(rd_index) < DEPTH) ? m_bias[rd_index] : 32'h0;
         if (m_busy == 0) begin
            if (load_valid) begin
               if (int'(load_index) < DEPTH) m_bias[load_index] <= load_data;
               else exp_idx_err <= 1'b1;
            end else if (err_valid) begin
               m_idx  <= err_index;
               m_last <= err_last;
               m_busy <= 2;
               if (int'(err_index) < DEPTH) m_res <= model_update(m_bias[err_index], err_data);
               else exp_idx_err <= 1'b1;
            end
         end else if (m_busy == 2) begin
            m_busy <= 1;
         end else begin
            if (int'(m_idx) < DEPTH) m_bias[m_idx] <= m_res;
            m_busy <= 0;
         end
      end
   end

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("cmp_err_ready", {31'b0, err_ready}, {31'b0, (m_busy == 0) && !load_valid});
         check("cmp_done", {31'b0, done}, {31'b0, (m_busy == 1) && m_last});
         check("cmp_idx_err", {31'b0, idx_err}, {31'b0, exp_idx_err});
         check("cmp_rd_data", rd_data, exp_rd);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] idx, input logic [31:0] data);
      load_valid = 1'b1; load_index = idx; load_data = data;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic read_chk(input logic [3:0] idx, input logic [31:0] exp);
      rd_index = idx;
      tick();
      check($sformatf("read_bias%0d", idx), rd_data, exp);
   endtask

   // Offers a term until accepted; returns the number of edges waited.
   task automatic accept_err(input logic [3:0] idx, input logic [31:0] data, input logic last,
                             output int waited);
      logic acc = 1'b0;
      err_valid = 1'b1; err_index = idx; err_data = data; err_last = last;
      waited = 0;
      while (!acc && waited < 10) begin
         #1;
         acc = err_ready;
         tick();
         waited++;
      end
      err_valid = 1'b0;
      check("accept_timeout", {31'b0, acc}, 32'd1);
   endtask

   task automatic send_err(input logic [3:0] idx, input logic [31:0] data, input logic last,
                           output int waited);
      accept_err(idx, data, last, waited);
      #1;
      check("calc_ready", {31'b0, err_ready}, 32'd0);
      check("calc_done", {31'b0, done}, 32'd0);
      tick();
      #1;
      check("wb_ready", {31'b0, err_ready}, 32'd0);
      check("wb_done", {31'b0, done}, {31'b0, last});
      tick();
      #1;
      check("idle_ready", {31'b0, err_ready}, 32'd1);
      check("idle_done", {31'b0, done}, 32'd0);
   endtask

   int w;
   logic [31:0] final_tbl [16];

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_index = '0; load_data = '0;
      err_valid = 1'b0; err_index = '0; err_data = '0; err_last = 1'b0; rd_index = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_idx_err", {31'b0, idx_err}, 32'd0);
      check("rst_err_ready", {31'b0, err_ready}, 32'd1);
      for (int i = 0; i < 16; i++) read_chk(4'(i), 32'h0);

      // 1.0 - 1.0/16 = 0.9375, with done on the WB cycle
      do_load(4'd3, 32'h3F800000);
      send_err(4'd3, 32'h3F800000, 1'b1, w);
      check("model_bias3", m_bias[3], 32'h3F700000);
      read_chk(4'd3, 32'h3F700000);

      // zero-encoded bias minus (-1.0)/16 = 0.0625
      send_err(4'd0, 32'hBF800000, 1'b0, w);
      check("model_bias0", m_bias[0], 32'h3D800000);
      read_chk(4'd0, 32'h3D800000);

      // err exponent 13 is below LR_SHIFT+10: no change
      send_err(4'd3, 32'h06800000, 1'b0, w);
      read_chk(4'd3, 32'h3F700000);

      // simultaneous load and err: load wins, err accepted on the next edge
      load_valid = 1'b1; load_index = 4'd5; load_data = 32'h40000000;
      err_valid = 1'b1; err_index = 4'd5; err_data = 32'h40000000; err_last = 1'b0;
      #1;
      check("ready_during_load", {31'b0, err_ready}, 32'd0);
      tick();
      load_valid = 1'b0;
      send_err(4'd5, 32'h40000000, 1'b0, w);
      check("accept_next_cycle", w, 32'd1);
      read_chk(4'd5, 32'h3FF00000);               // 2.0 - 0.125

      // back-to-back on the same entry sees the previous write
      send_err(4'd5, 32'h40000000, 1'b1, w);
      read_chk(4'd5, 32'h3FE00000);               // 1.875 - 0.125

      // negative bias: -1.0 - 0.0625
      do_load(4'd2, 32'hBF800000);
      send_err(4'd2, 32'h3F800000, 1'b0, w);
      read_chk(4'd2, 32'hBF880000);

      // sum carries into the next binade: 1.0 + 1.0
      do_load(4'd1, 32'h3F800000);
      send_err(4'd1, 32'hC1800000, 1'b0, w);
      read_chk(4'd1, 32'h40000000);

      // out-of-range err index: sticky flag, done, nothing written
      send_err(4'd12, 32'h3F800000, 1'b1, w);
      check("idx_err_set", {31'b0, idx_err}, 32'd1);
      for (int i = 0; i < 16; i++) final_tbl[i] = 32'h0;
      final_tbl[0] = 32'h3D800000; final_tbl[1] = 32'h40000000;
      final_tbl[2] = 32'hBF880000; final_tbl[3] = 32'h3F700000;
      final_tbl[5] = 32'h3FE00000;
      for (int i = 0; i < 16; i++) read_chk(4'(i), final_tbl[i]);
      check("idx_err_sticky", {31'b0, idx_err}, 32'd1);

      // reset in the middle of CALC aborts the update
      rd_index = 4'd0;
      accept_err(4'd0, 32'h3F800000, 1'b1, w);
      #2 reset = 1'b1;
      #1;
      check("midrst_rd_data", rd_data, 32'h0);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_idx_err", {31'b0, idx_err}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("postrst_ready", {31'b0, err_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("postrst_no_done", {31'b0, done}, 32'd0);
      end
      for (int i = 0; i < 16; i++) read_chk(4'(i), 32'h0);

      // out-of-range load index: flag set, no write
      do_load(4'd13, 32'h3F800000);
      #1;
      check("load_idx_err", {31'b0, idx_err}, 32'd1);
      for (int i = 0; i < 16; i++) read_chk(4'(i), 32'h0);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
